apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Shares a single APB4 master port (the `ifApbMaster` signal set) among `NUM_REQ` internal requesters such as the register-access sequencer and the debug/bridge path. Round-robin arbitration, APB SETUP/ACCESS sequencing, wait-state handling, a wait-state timeout, and per-requester response return. It sits between the requesters and the APB slave fabric (the UART register block).

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `TIMEOUT`, 16: maximum ACCESS cycles without `pready` before abort; 0 disables the timeout.

Ports. Clock and reset: one clock, `pclk`; reset `preset_n` is asynchronous and active-low.
- `pclk`  in  1  clock.
- `preset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse.
- `req_write`  in  NUM_REQ  1 = write.
- `req_addr`  in  NUM_REQ*32  flattened; requester i at [32i+31:32i].
- `req_wdata`  in  NUM_REQ*32  flattened write data.
- `req_strb`  in  NUM_REQ*4  flattened byte strobes.
- `req_prot`  in  NUM_REQ*3  flattened protection bits.
- `rsp_valid`  out  NUM_REQ  one-hot completion pulse.
- `rsp_rdata`  out  32  read data, shared by all requesters.
- `rsp_err`  out  1  error flag (`pslverr` or timeout), shared.
- `psel`, `penable`, `pwrite`  out  1 each  APB control.
- `paddr`, `pwdata`  out  32 each  APB address and write data.
- `pstrb`  out  4  APB write strobes.
- `pprot`  out  3  APB protection.
- `prdata`  in  32  APB read data.
- `pready`, `pslverr`  in  1 each  APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: `psel=0`, `penable=0`.
  - SETUP: `psel=1`, `penable=0`.
  - ACCESS: `psel=1`, `penable=1`.
- Grant point: the FSM is in IDLE, or in ACCESS with the transfer completing (`pready=1` or timeout).
  - At a grant point with any `req_valid` set, the arbiter picks grantee g.
  - `req_ready[g]=1` combinationally in that cycle.
  - g's fields are latched into the APB output registers at the clock edge.
  - The next state is SETUP.
- Without any request at a grant point, the next state is IDLE.
- SETUP always moves to ACCESS after one cycle.
- ACCESS holds until `pready=1` or a timeout.
- Round robin:
  - Search starts at (last grantee + 1) mod NUM_REQ.
  - The pointer advances only on a grant.
  - After reset, requester 0 has highest priority.
- Requester rule: `req_valid` and its fields must stay stable until `req_ready`. Dropping `req_valid` before the grant is legal; that request is simply not granted.
- Reads: `pstrb` is forced to 4'b0000 whatever `req_strb` holds.
- Completion with `pready=1`:
  - Next cycle: `rsp_valid[g]=1` for one cycle.
  - `rsp_rdata` = captured `prdata` for reads, 0 for writes.
  - `rsp_err` = captured `pslverr`.
- Timeout:
  - A wait counter counts ACCESS cycles with `pready=0`.
  - When the count reaches TIMEOUT, the transfer ends that cycle and the bus releases.
  - Next cycle: `rsp_valid[g]=1`, `rsp_err=1`, `rsp_rdata=0`.
  - The counter clears on entry to SETUP.
- `paddr`, `pwrite`, `pwdata`, `pstrb`, `pprot` hold from SETUP through the final ACCESS cycle and keep their last value in IDLE.
- Reset, asynchronous and at any point including mid-transfer:
  - State goes to IDLE and the round-robin pointer to 0.
  - All outputs are 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `pstrb`, `pprot`, `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`.
  - An in-flight response is dropped.

## Timing
- Zero-wait transfer: grant in cycle 0, SETUP in cycle 1, ACCESS with `pready` in cycle 2, `rsp_valid` in cycle 3.
- Each wait state adds one cycle.
- Back-to-back transfers: the next SETUP immediately follows the completing ACCESS. `psel` stays high and `penable` drops for one cycle. There is no IDLE bubble.
- A new request arriving in the same cycle as a completion is eligible for that grant point.
- `rsp_valid` for transfer N may coincide with SETUP of transfer N+1.
- Timeout abort happens in ACCESS cycle TIMEOUT, counting the first ACCESS cycle as 1.

## Structure
- Package `apb_arb_pkg`:
  - `apb_state_e` enum {IDLE, SETUP, ACCESS}.
  - APB width constants: ADDR_W=32, DATA_W=32, STRB_W=4, PROT_W=3.
  - Default `TIMEOUT` value.
- Sub-module `rr_arbiter`, parameterized by N.
  - Inputs: `req` vector, `advance` strobe.
  - Outputs: one-hot `grant`, registered priority pointer.
- Top level: FSM, request mux/latch, wait counter, response register.

## Test plan
- Single write: req0 `addr=0x0000_0010`, `wdata=0xA5A5_0001`, `strb=0xF`, `pready` tied 1 → one SETUP cycle then one ACCESS cycle with matching `paddr`/`pwdata`/`pstrb`; `rsp_valid[0]` 3 cycles after grant, `rsp_err=0`, `rsp_rdata=0`.
- Read with 2 wait states: req1 read `0x0000_0004`, `req_strb=0xF`, slave returns `prdata=0x1234_5678` on the third ACCESS cycle → `pstrb=0`; `rsp_rdata=0x1234_5678` on `rsp_valid[1]`; `penable` high for exactly 3 cycles.
- Contention: req0 and req1 both valid continuously, 4 transfers → grant order 0,1,0,1; back-to-back SETUPs with no IDLE between them.
- Slave error: write completes with `pslverr=1` → `rsp_err=1` on that `rsp_valid`; the next transfer has `rsp_err=0`.
- Timeout: `TIMEOUT=16`, `pready` held 0 → `psel`/`penable` drop after ACCESS cycle 16; `rsp_err=1`, `rsp_rdata=0`; arbiter serves the next request.
- Reset mid-ACCESS: assert `preset_n=0` during a wait state → all outputs 0 immediately; no `rsp_valid`; after release, requester 0 wins a tie.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and constants for the APB master arbiter.
//   apb_state_e : bus FSM states (IDLE / SETUP / ACCESS)
//   apb_req_t   : one requester's transfer fields, as latched onto the bus
//   cnt_w()     : width of the wait-state counter for a given TIMEOUT
package apb_arb_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int STRB_W      = 4;
  localparam int PROT_W      = 3;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [PROT_W-1:0] prot;
  } apb_req_t;

  // At least one bit so a disabled timeout (0) still yields a legal vector.
  function automatic int cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// rr_arbiter: round-robin picker over N request lines.
//   pclk, preset_n : clock, async active-low reset
//   req            : request vector
//   advance        : a grant was taken this cycle; move priority past grantee
//   grant          : one-hot winner (combinational), zero when no request
//   ptr            : registered index of the highest-priority requester
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          pclk,
  input  logic          preset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic          found;
  logic [PW-1:0] gidx;
  int            idx;

  // Scan N slots starting at ptr, wrapping; first hit wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)
      ptr <= '0;
    else if (advance && found)
      ptr <= (gidx == PW'(N-1)) ? '0 : PW'(gidx + 1'b1);
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB4 master port among NUM_REQ requesters.
//   pclk, preset_n         : clock, async active-low reset
//   req_valid/req_ready    : per-requester request / one-hot accept pulse
//   req_write/addr/wdata/strb/prot : flattened request fields (requester i
//                            occupies slice i of each vector)
//   rsp_valid              : one-hot completion pulse, cycle after transfer end
//   rsp_rdata, rsp_err     : shared response data and error (pslverr/timeout)
//   psel..pprot            : APB master outputs, registered
//   prdata, pready, pslverr: APB slave response
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_W-1:0] req_strb,
  input  logic [NUM_REQ*PROT_W-1:0] req_prot,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic [STRB_W-1:0]         pstrb,
  output logic [PROT_W-1:0]         pprot,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_e           state, state_nx;
  logic [CW-1:0]        wait_cnt;
  logic [NUM_REQ-1:0]   grant, cur_g;
  logic [PW-1:0]        rr_ptr;
  logic                 tmo, xfer_done, grant_pt, grant_any;
  apb_req_t             reqs [NUM_REQ];
  apb_req_t             sel;

  // Unflatten request fields into per-requester structs.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign reqs[i] = '{write: req_write[i],
                       addr:  req_addr [i*ADDR_W +: ADDR_W],
                       wdata: req_wdata[i*DATA_W +: DATA_W],
                       strb:  req_strb [i*STRB_W +: STRB_W],
                       prot:  req_prot [i*PROT_W +: PROT_W]};
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .pclk     (pclk),
    .preset_n (preset_n),
    .req      (req_valid),
    .advance  (grant_any),
    .grant    (grant),
    .ptr      (rr_ptr)
  );

  // Abort in ACCESS cycle TIMEOUT: counter holds (cycle-1) there. A pready in
  // the same cycle wins, so the slave's real response is kept.
  assign tmo       = (TIMEOUT != 0) && (state == ACCESS) && !pready &&
                     (wait_cnt == CW'(TIMEOUT - 1));
  assign xfer_done = (state == ACCESS) && (pready || tmo);
  assign grant_pt  = (state == IDLE) || xfer_done;
  // Gated by reset so req_ready reads 0 while reset is held.
  assign grant_any = grant_pt && (|req_valid) && preset_n;
  assign req_ready = grant_any ? grant : '0;

  // One-hot select of the grantee's fields.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) sel = reqs[i];
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    psel     = 1'b0;
    penable  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) state_nx = SETUP;
      end
      SETUP: begin
        psel     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (xfer_done) state_nx = grant_any ? SETUP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wait counter: cleared whenever SETUP is entered, counts stalled ACCESS.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)
      wait_cnt <= '0;
    else if (state_nx == SETUP)
      wait_cnt <= '0;
    else if (state == ACCESS && !pready)
      wait_cnt <= wait_cnt + 1'b1;
  end

  // Bus field registers: loaded only at a grant, held otherwise (incl. IDLE).
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
      pprot  <= '0;
      cur_g  <= '0;
    end else if (grant_any) begin
      pwrite <= sel.write;
      paddr  <= sel.addr;
      pwdata <= sel.wdata;
      pstrb  <= sel.write ? sel.strb : '0;
      pprot  <= sel.prot;
      cur_g  <= grant;
    end
  end

  // Response: one-cycle pulse to the owner of the finishing transfer. pwrite
  // still describes that transfer here even if a new grant loads this edge.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (xfer_done) begin
        rsp_valid <= cur_g;
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed self-checking bench, NUM_REQ=2, TIMEOUT=16.
// Inputs are driven on the falling edge, outputs sampled #1 later.
module tb_apb_master_arbiter;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(.NUM_REQ(2), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    req_valid[i]        = v;
    req_write[i]        = w;
    req_addr[i*32 +: 32]  = a;
    req_wdata[i*32 +: 32] = d;
    req_strb[i*4 +: 4]    = s;
    req_prot[i*3 +: 3]    = p;
  endtask

  task automatic test_reset;
    preset_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++;
      $display("FAIL rst_ctrl got=%b exp=000", {psel, penable, pwrite}); end
    total++; if ({paddr, pwdata, pstrb, pprot} !== 71'd0) begin bad++;
      $display("FAIL rst_bus got=%h exp=0", {paddr, pwdata, pstrb, pprot}); end
    total++; if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== 37'd0) begin bad++;
      $display("FAIL rst_rsp got=%h exp=0", {req_ready, rsp_valid, rsp_rdata, rsp_err}); end
    @(negedge pclk); preset_n = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  // Zero-wait write from requester 0.
  task automatic test_single_write;
    pready = 1'b1;
    @(negedge pclk);
    set_req(0, 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 4'hF, 3'b010);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++;
      $display("FAIL wr_ready got=%b exp=01", req_ready); end
    @(negedge pclk); req_valid = '0; #1;  // SETUP
    total++; if ({psel, penable, pwrite} !== 3'b101) begin bad++;
      $display("FAIL wr_setup_ctrl got=%b exp=101", {psel, penable, pwrite}); end
    total++; if ({paddr, pwdata, pstrb, pprot} !== {32'h10, 32'hA5A5_0001, 4'hF, 3'b010}) begin bad++;
      $display("FAIL wr_setup_bus got=%h %h %h %h", paddr, pwdata, pstrb, pprot); end
    @(negedge pclk); #1;                  // ACCESS
    total++; if ({psel, penable, rsp_valid} !== 4'b1100) begin bad++;
      $display("FAIL wr_access got=%b exp=1100", {psel, penable, rsp_valid}); end
    @(negedge pclk); #1;                  // response
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b0, 32'h0}) begin bad++;
      $display("FAIL wr_rsp got=%b %b %h exp=01 0 0", rsp_valid, rsp_err, rsp_rdata); end
    total++; if (psel !== 1'b0) begin bad++;
      $display("FAIL wr_idle got=%b exp=0", psel); end
    @(negedge pclk); #1;
    total++; if (rsp_valid !== 2'b00) begin bad++;
      $display("FAIL wr_rsp_pulse got=%b exp=00", rsp_valid); end
  endtask

  // Read from requester 1 with two wait states.
  task automatic test_read_wait;
    int pen = 0;
    pready = 1'b0;
    @(negedge pclk);
    set_req(1, 1'b1, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 3'b000);
    #1;
    total++; if (req_ready !== 2'b10) begin bad++;
      $display("FAIL rd_ready got=%b exp=10", req_ready); end
    @(negedge pclk); req_valid = '0; #1;
    total++; if ({pwrite, pstrb, paddr} !== {1'b0, 4'h0, 32'h4}) begin bad++;
      $display("FAIL rd_setup got=%b %h %h exp=0 0 4", pwrite, pstrb, paddr); end
    for (int w = 0; w < 3; w++) begin
      @(negedge pclk);
      pready = (w == 2);
      prdata = (w == 2) ? 32'h1234_5678 : 32'hBAD0_BAD0;
      #1;
      if (penable) pen++;
    end
    @(negedge pclk); pready = 1'b0; prdata = '0; #1;
    total++; if (pen !== 3) begin bad++;
      $display("FAIL rd_penable_cycles got=%0d exp=3", pen); end
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'h1234_5678}) begin bad++;
      $display("FAIL rd_rsp got=%b %b %h exp=10 0 12345678", rsp_valid, rsp_err, rsp_rdata); end
    total++; if (penable !== 1'b0) begin bad++;
      $display("FAIL rd_end got=%b exp=0", penable); end
    repeat (2) @(negedge pclk);
  endtask

  // Both requesters valid; four back-to-back zero-wait transfers.
  task automatic test_back_to_back;
    logic [1:0]  exp_rdy [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic [31:0] ea;
    pready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge pclk);
      if (k == 0) begin
        set_req(0, 1'b1, 1'b1, 32'h100, 32'h1, 4'h3, 3'b000);
        set_req(1, 1'b1, 1'b1, 32'h200, 32'h2, 4'hC, 3'b001);
      end
      if (k == 7) req_valid = '0;
      #1;
      total++; if (req_ready !== exp_rdy[k]) begin bad++;
        $display("FAIL b2b_grant[%0d] got=%b exp=%b", k, req_ready, exp_rdy[k]); end
      if (k >= 1) begin
        total++; if ({psel, penable} !== {1'b1, (k % 2 == 0)}) begin bad++;
          $display("FAIL b2b_bus[%0d] got=%b%b exp=1%b", k, psel, penable, (k % 2 == 0)); end
      end
      if (k % 2 == 1) begin
        ea = (k == 1 || k == 5) ? 32'h100 : 32'h200;
        total++; if (paddr !== ea) begin bad++;
          $display("FAIL b2b_addr[%0d] got=%h exp=%h", k, paddr, ea); end
      end
    end
    repeat (3) @(negedge pclk);
  endtask

  // Drive one transfer; report accept and response observed.
  task automatic do_xfer(input int i, input logic w, input logic [31:0] a,
                         input logic err, output logic [1:0] rdy,
                         output logic [1:0] rv, output logic re);
    pready = 1'b0;
    @(negedge pclk);
    set_req(i, 1'b1, w, a, 32'h55, 4'hF, 3'b000);
    #1; rdy = req_ready;
    @(negedge pclk); req_valid = '0;
    @(negedge pclk); pready = 1'b1; pslverr = err;
    @(negedge pclk); pready = 1'b0; pslverr = 1'b0;
    #1; rv = rsp_valid; re = rsp_err;
  endtask

  task automatic test_slave_error;
    logic [1:0] rdy, rv;
    logic       re;
    do_xfer(0, 1'b1, 32'h20, 1'b1, rdy, rv, re);
    total++; if ({rdy, rv, re} !== {2'b01, 2'b01, 1'b1}) begin bad++;
      $display("FAIL err_rsp got=%b %b %b exp=01 01 1", rdy, rv, re); end
    do_xfer(1, 1'b1, 32'h24, 1'b0, rdy, rv, re);
    total++; if ({rdy, rv, re} !== {2'b10, 2'b10, 1'b0}) begin bad++;
      $display("FAIL err_clear got=%b %b %b exp=10 10 0", rdy, rv, re); end
    @(negedge pclk);
  endtask

  // pready held low: abort in ACCESS cycle 16, then serve requester 1.
  task automatic test_timeout;
    int pen = 0;
    pready = 1'b0; prdata = 32'hDEAD_BEEF;
    @(negedge pclk);
    set_req(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, 3'b000);
    #1;
    total++; if (req_ready !== 2'b01) begin bad++;
      $display("FAIL to_ready got=%b exp=01", req_ready); end
    @(negedge pclk); req_valid = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge pclk);
      if (k == 16) set_req(1, 1'b1, 1'b1, 32'h40, 32'h77, 4'h1, 3'b000);
      #1;
      if (penable) pen++;
      if (k == 16) begin
        total++; if (req_ready !== 2'b10) begin bad++;
          $display("FAIL to_next_grant got=%b exp=10", req_ready); end
      end
    end
    total++; if (pen !== 16) begin bad++;
      $display("FAIL to_access_cycles got=%0d exp=16", pen); end
    @(negedge pclk); req_valid = '0; #1;
    total++; if ({psel, penable, paddr} !== {1'b1, 1'b0, 32'h40}) begin bad++;
      $display("FAIL to_release got=%b%b %h exp=10 40", psel, penable, paddr); end
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b1, 32'h0}) begin bad++;
      $display("FAIL to_rsp got=%b %b %h exp=01 1 0", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge pclk); pready = 1'b1;
    @(negedge pclk); pready = 1'b0; prdata = '0; #1;
    total++; if ({rsp_valid, rsp_err} !== {2'b10, 1'b0}) begin bad++;
      $display("FAIL to_after got=%b %b exp=10 0", rsp_valid, rsp_err); end
    repeat (2) @(negedge pclk);
  endtask

  // Reset during a wait state; response dropped; pointer back to 0.
  task automatic test_reset_mid;
    pready = 1'b0;
    @(negedge pclk);
    set_req(0, 1'b1, 1'b1, 32'h50, 32'h99, 4'hF, 3'b111);
    @(negedge pclk); req_valid = '0;
    @(negedge pclk);                     // ACCESS 1
    @(negedge pclk);                     // ACCESS 2
    #1;
    total++; if (penable !== 1'b1) begin bad++;
      $display("FAIL rm_in_access got=%b exp=1", penable); end
    #1;
    pready = 1'b1; preset_n = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h60, 32'h1, 4'hF, 3'b000);
    set_req(1, 1'b1, 1'b1, 32'h70, 32'h2, 4'hF, 3'b000);
    #1;
    total++; if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot} !== 74'd0) begin bad++;
      $display("FAIL rm_bus got=%b%b%b %h %h %h %h", psel, penable, pwrite, paddr, pwdata, pstrb, pprot); end
    total++; if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== 37'd0) begin bad++;
      $display("FAIL rm_rsp got=%b %b %h %b", req_ready, rsp_valid, rsp_rdata, rsp_err); end
    @(negedge pclk); #1;
    total++; if (rsp_valid !== 2'b00) begin bad++;
      $display("FAIL rm_dropped got=%b exp=00", rsp_valid); end
    @(negedge pclk); preset_n = 1'b1; #1;
    total++; if ({req_ready, rsp_valid} !== {2'b01, 2'b00}) begin bad++;
      $display("FAIL rm_tie got=%b %b exp=01 00", req_ready, rsp_valid); end
    @(negedge pclk); req_valid = '0;
    repeat (3) @(negedge pclk);
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_wait;
    test_back_to_back;
    test_slave_error;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
